// File: rtl/axis_vid_out_timing.sv
// Raster timing generator that locks an AXI4-Stream pixel stream to VGA/DVI timing
// through a small FWFT FIFO. Define VIDOUT_EOL_CHECK_EN to add tlast/end-of-line checking.

module axis_vid_out_timing #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter logic        HSYNC_POL       = 1'b0,
    parameter logic        VSYNC_POL       = 1'b0,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
    input  logic        s_axis_vid_aclk,
    input  logic        s_axis_vid_aresetn,
    input  logic [31:0] s_axis_vid_tdata,
    input  logic        s_axis_vid_tvalid,
    output logic        s_axis_vid_tready,
    input  logic        s_axis_vid_tuser,
    input  logic        s_axis_vid_tlast,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_de,
    output logic [23:0] vid_data,
    output logic        locked,
    output logic [15:0] underflow_count,
    output logic [15:0] sof_err_count
`ifdef VIDOUT_EOL_CHECK_EN
    ,
    output logic [15:0] eol_err_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);
`ifdef VIDOUT_EOL_CHECK_EN
    localparam int FW      = 26;
`else
    localparam int FW      = 25;
`endif

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

    typedef enum logic [1:0] {UNLOCKED, ARMED, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          de_int, sof_pos, hsync_int, vsync_int;
    logic          ready_en, beat, push, pop, flush;
    logic          uf_inc, sof_inc, eol_inc;
    logic [23:0]   pix;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [FW-1:0] wr_entry, head;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty;
    logic          unused_bits;

    // Free-running raster counters.
    always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
        if (!s_axis_vid_aresetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign de_int    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign sof_pos   = (hcnt == '0) && (vcnt == '0);
    assign hsync_int = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vsync_int = (vcnt >= VS_BEG) && (vcnt < VS_END);

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

`ifdef VIDOUT_EOL_CHECK_EN
    assign wr_entry    = {s_axis_vid_tlast, s_axis_vid_tuser, s_axis_vid_tdata[23:0]};
    assign unused_bits = ^s_axis_vid_tdata[31:24];
`else
    assign wr_entry    = {s_axis_vid_tuser, s_axis_vid_tdata[23:0]};
    assign unused_bits = ^{s_axis_vid_tdata[31:24], s_axis_vid_tlast};
`endif

    // While unlocked every beat is taken so the stream can be scanned for its next SOF.
    assign s_axis_vid_tready = ready_en && ((state == UNLOCKED) || !full);
    assign beat              = s_axis_vid_tvalid && s_axis_vid_tready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        pop       = 1'b0;
        flush     = 1'b0;
        uf_inc    = 1'b0;
        sof_inc   = 1'b0;
        eol_inc   = 1'b0;
        pix       = de_int ? UNDERFLOW_COLOR : 24'h000000;
        case (state)
            UNLOCKED: if (beat && s_axis_vid_tuser) state_nxt = ARMED;
            ARMED: begin
                if (sof_pos && !empty) begin
                    pop       = 1'b1;
                    pix       = head[23:0];
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (de_int && empty) begin
                    uf_inc    = 1'b1;
                    flush     = 1'b1;
                    state_nxt = UNLOCKED;
                end else if (de_int) begin
                    pop = 1'b1;
                    pix = head[23:0];
                    if (head[24] != sof_pos) begin
                        sof_inc   = 1'b1;
                        flush     = 1'b1;
                        state_nxt = UNLOCKED;
                    end
`ifdef VIDOUT_EOL_CHECK_EN
                    if (head[25] != (hcnt == H_EOL)) begin
                        eol_inc   = 1'b1;
                        flush     = 1'b1;
                        state_nxt = UNLOCKED;
                    end
`endif
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
        push = beat && !flush && ((state != UNLOCKED) || s_axis_vid_tuser);
    end

    // NOTE: the storage array has no reset; only the pointers define FIFO contents.
    always_ff @(posedge s_axis_vid_aclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

    always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
        if (!s_axis_vid_aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Lock FSM, pin registers and error counters share one register stage.
    always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
        if (!s_axis_vid_aresetn) begin
            state           <= UNLOCKED;
            vid_hsync       <= ~HSYNC_POL;
            vid_vsync       <= ~VSYNC_POL;
            vid_de          <= 1'b0;
            vid_data        <= 24'h000000;
            locked          <= 1'b0;
            underflow_count <= 16'h0000;
            sof_err_count   <= 16'h0000;
`ifdef VIDOUT_EOL_CHECK_EN
            eol_err_count   <= 16'h0000;
`endif
        end else begin
            state     <= state_nxt;
            vid_hsync <= hsync_int ? HSYNC_POL : ~HSYNC_POL;
            vid_vsync <= vsync_int ? VSYNC_POL : ~VSYNC_POL;
            vid_de    <= de_int;
            vid_data  <= pix;
            locked    <= (state_nxt == LOCKED);
            if (uf_inc && (underflow_count != 16'hFFFF)) underflow_count <= underflow_count + 16'd1;
            if (sof_inc && (sof_err_count != 16'hFFFF))  sof_err_count   <= sof_err_count + 16'd1;
`ifdef VIDOUT_EOL_CHECK_EN
            if (eol_inc && (eol_err_count != 16'hFFFF))  eol_err_count   <= eol_err_count + 16'd1;
`endif
        end
    end

endmodule

// File: tb/tb_axis_vid_out_timing.sv
// Directed bench for axis_vid_out_timing on a reduced 14x7 raster with an 8-entry FIFO.
// Each scenario task drives a beat queue and compares pins inline against hand-derived values.

module tb_axis_vid_out_timing;

    localparam int HT = 14;
    localparam int VT = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tdata;
    logic        tvalid, tuser, tlast;
    logic        tready;
    logic        vid_hsync, vid_vsync, vid_de, locked;
    logic [23:0] vid_data;
    logic [15:0] underflow_count, sof_err_count;
`ifdef VIDOUT_EOL_CHECK_EN
    logic [15:0] eol_err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Beat queue entries are {tuser, tlast, pixel}.
    logic [25:0] q[$];
    bit          accept;
    int          drop_left;
    bit          drop_arm;
    int          rh, rv, rf;   // raster position of the cycle now in progress
    int          oh, ov, of;   // raster position the pins currently show

    always #5 clk = ~clk;

    axis_vid_out_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .FIFO_DEPTH(8), .UNDERFLOW_COLOR(24'h000000)
    ) dut (
        .s_axis_vid_aclk(clk),
        .s_axis_vid_aresetn(rst_n),
        .s_axis_vid_tdata(tdata),
        .s_axis_vid_tvalid(tvalid),
        .s_axis_vid_tready(tready),
        .s_axis_vid_tuser(tuser),
        .s_axis_vid_tlast(tlast),
        .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync),
        .vid_de(vid_de),
        .vid_data(vid_data),
        .locked(locked),
        .underflow_count(underflow_count),
        .sof_err_count(sof_err_count)
`ifdef VIDOUT_EOL_CHECK_EN
        ,
        .eol_err_count(eol_err_count)
`endif
    );

    function automatic logic [23:0] pat(input int v, input int h);
        return 24'(16 * v + h);
    endfunction

    task automatic push_frame(input bit bad_sof_line2);
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 8; c++) begin
                bit u;
                u = (l == 0 && c == 0) || (bad_sof_line2 && l == 2 && c == 0);
                q.push_back({u, c == 7, pat(l, c)});
            end
        end
    endtask

    task automatic drive_inputs();
        if (q.size() > 0) begin
            tdata = {8'hA5, q[0][23:0]};
            tuser = q[0][25];
            tlast = q[0][24];
        end
        tvalid = (q.size() > 0) && (drop_left == 0);
    endtask

    // Advance one clock: update the raster model, retire an accepted beat, drive the
    // next beat, then stop on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        oh = rh; ov = rv; of = rf;
        if (rh == HT - 1) begin
            rh = 0;
            if (rv == VT - 1) begin rv = 0; rf++; end
            else rv++;
        end else begin
            rh++;
        end
        #1;
        if (accept) void'(q.pop_front());
        if (drop_left > 0) drop_left--;
        if (drop_arm && rf == 1 && rv == 1 && rh == 0) begin
            drop_left = 20;
            drop_arm  = 0;
        end
        drive_inputs();
        @(negedge clk);
        accept = tvalid && tready;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = '0;
        accept = 0; drop_left = 0; drop_arm = 0;
        rh = 0; rv = 0; rf = 0; oh = 0; ov = 0; of = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({vid_de, vid_data, vid_hsync, vid_vsync, locked, tready} !== {1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_pins: got de=%b data=%h hs=%b vs=%b lk=%b rdy=%b, expected 0 000000 1 1 0 0",
                     vid_de, vid_data, vid_hsync, vid_vsync, locked, tready);
        end
        n_cmp++;
        if ({underflow_count, sof_err_count} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_counts: got uf=%0d sof=%0d, expected 0 0", underflow_count, sof_err_count);
        end
        do_reset();
        n_cmp++;
        if (tready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_clock: got %b expected 0", tready);
        end
        step();
        n_cmp++;
        if ({tready, vid_de, vid_data, vid_hsync, locked} !== {1'b1, 1'b1, 24'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL first_clock: got rdy=%b de=%b data=%h hs=%b lk=%b, expected 1 1 000000 1 0",
                     tready, vid_de, vid_data, vid_hsync, locked);
        end
    endtask

    task automatic test_raster();
        logic [27:0] got, exp;
        do_reset();
        drive_inputs();
        while (rf < 2) begin
            step();
            got = {vid_de, vid_hsync, vid_vsync, locked, vid_data};
            exp = {oh < 8 && ov < 4, !(oh == 10 || oh == 11), ov != 5, 1'b0, 24'h0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL raster f%0d v%0d h%0d: got %h expected %h", of, ov, oh, got, exp);
            end
        end
    endtask

    task automatic test_lock(input int n_garbage);
        logic [25:0] got, exp;
        bit de_e, lk_e;
        do_reset();
        for (int g = 0; g < n_garbage; g++) q.push_back({1'b0, 1'b0, 24'hBAD000 + 24'(g)});
        for (int f = 0; f < 8; f++) push_frame(1'b0);
        drive_inputs();
        accept = tvalid && tready;
        while (rf < 3) begin
            step();
            de_e = (oh < 8) && (ov < 4);
            lk_e = (of >= 1);
            got  = {locked, vid_de, vid_data};
            exp  = {lk_e, de_e, (de_e && lk_e) ? pat(ov, oh) : 24'h0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lock_g%0d f%0d v%0d h%0d: got %h expected %h", n_garbage, of, ov, oh, got, exp);
            end
            if (of == 2 && ov == 1 && oh == 3) begin
                n_cmp++;
                if (vid_data !== 24'h000013) begin
                    n_bad++;
                    $display("FAIL lock_pixel_13: got %h expected 000013", vid_data);
                end
            end
        end
        n_cmp++;
        if ({underflow_count, sof_err_count} !== 32'h0) begin
            n_bad++;
            $display("FAIL lock_counts: got uf=%0d sof=%0d, expected 0 0", underflow_count, sof_err_count);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int f = 0; f < 8; f++) push_frame(1'b0);
        drop_arm = 1;
        drive_inputs();
        while (rf < 3) begin
            step();
            if (of == 1 && ov == 1 && oh == 7) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h000017}) begin
                    n_bad++;
                    $display("FAIL uf_before: got lk=%b data=%h, expected 1 000017", locked, vid_data);
                end
            end
            if (of == 1 && ov == 2 && oh == 0) begin
                n_cmp++;
                if ({vid_de, locked, vid_data, underflow_count} !== {1'b1, 1'b0, 24'h0, 16'd1}) begin
                    n_bad++;
                    $display("FAIL uf_starved: got de=%b lk=%b data=%h uf=%0d, expected 1 0 000000 1",
                             vid_de, locked, vid_data, underflow_count);
                end
            end
            if (of == 1 && ov == 3 && oh == 0) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL uf_unlocked: got lk=%b expected 0", locked);
                end
            end
            if (of == 2 && ov == 0 && oh == 0) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h0}) begin
                    n_bad++;
                    $display("FAIL uf_relock: got lk=%b data=%h, expected 1 000000", locked, vid_data);
                end
            end
            if (of == 2 && ov == 1 && oh == 3) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h000013}) begin
                    n_bad++;
                    $display("FAIL uf_relock_pix: got lk=%b data=%h, expected 1 000013", locked, vid_data);
                end
            end
        end
        n_cmp++;
        if ({underflow_count, sof_err_count} !== {16'd1, 16'd0}) begin
            n_bad++;
            $display("FAIL uf_counts: got uf=%0d sof=%0d, expected 1 0", underflow_count, sof_err_count);
        end
    endtask

    task automatic test_sof_err();
        do_reset();
        push_frame(1'b1);
        for (int f = 0; f < 7; f++) push_frame(1'b0);
        drive_inputs();
        while (rf < 3) begin
            step();
            if (of == 1 && ov == 1 && oh == 7) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sof_before: got lk=%b expected 1", locked);
                end
            end
            if (of == 1 && ov == 2 && oh == 0) begin
                n_cmp++;
                if ({locked, vid_data, sof_err_count} !== {1'b0, 24'h000020, 16'd1}) begin
                    n_bad++;
                    $display("FAIL sof_detect: got lk=%b data=%h sof=%0d, expected 0 000020 1",
                             locked, vid_data, sof_err_count);
                end
            end
            if (of == 1 && ov == 2 && oh == 1) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b0, 24'h0}) begin
                    n_bad++;
                    $display("FAIL sof_after: got lk=%b data=%h, expected 0 000000", locked, vid_data);
                end
            end
            if (of == 2 && ov == 0 && oh == 0) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sof_relock: got lk=%b expected 1", locked);
                end
            end
            if (of == 2 && ov == 2 && oh == 0) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h000020}) begin
                    n_bad++;
                    $display("FAIL sof_relock_pix: got lk=%b data=%h, expected 1 000020", locked, vid_data);
                end
            end
        end
        n_cmp++;
        if ({underflow_count, sof_err_count} !== {16'd0, 16'd1}) begin
            n_bad++;
            $display("FAIL sof_counts: got uf=%0d sof=%0d, expected 0 1", underflow_count, sof_err_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int f = 0; f < 8; f++) push_frame(1'b0);
        drive_inputs();
        while (!(rf == 1 && rv == 2 && rh == 3)) step();
        n_cmp++;
        if ({locked, vid_de} !== 2'b11) begin
            n_bad++;
            $display("FAIL mid_pre_reset: got lk=%b de=%b, expected 1 1", locked, vid_de);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vid_de, vid_data, vid_hsync, vid_vsync, locked, tready} !== {1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL mid_reset_pins: got de=%b data=%h hs=%b vs=%b lk=%b rdy=%b, expected 0 000000 1 1 0 0",
                     vid_de, vid_data, vid_hsync, vid_vsync, locked, tready);
        end
        accept = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rh = 0; rv = 0; rf = 0;
        while (rf < 2) begin
            step();
            if (of == 0 && ov == 0 && oh == 0) begin
                n_cmp++;
                if ({locked, vid_de} !== 2'b01) begin
                    n_bad++;
                    $display("FAIL mid_restart: got lk=%b de=%b, expected 0 1", locked, vid_de);
                end
            end
            if (of == 1 && ov == 0 && oh == 0) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h0}) begin
                    n_bad++;
                    $display("FAIL mid_relock: got lk=%b data=%h, expected 1 000000", locked, vid_data);
                end
            end
            if (of == 1 && ov == 1 && oh == 3) begin
                n_cmp++;
                if ({locked, vid_data} !== {1'b1, 24'h000013}) begin
                    n_bad++;
                    $display("FAIL mid_relock_pix: got lk=%b data=%h, expected 1 000013", locked, vid_data);
                end
            end
        end
        n_cmp++;
        if ({underflow_count, sof_err_count} !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_counts: got uf=%0d sof=%0d, expected 0 0", underflow_count, sof_err_count);
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        test_reset();
        test_raster();
        test_lock(0);
        test_lock(5);
        test_underflow();
        test_sof_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
